// File: rtl/memory_hub.sv
// memory_hub: four-bank host RAM with registered two-cycle internal read ports.
// Duty table reads fall back to an arcsine pulse-width ROM until the host overwrites a word.
module memory_hub (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_EN,
    input  logic        MEM_WE,
    input  logic [1:0]  MEM_SEL,
    input  logic [14:0] MEM_ADDR,
    input  logic [15:0] MEM_DIN,
    output logic [15:0] MEM_DOUT,
    input  logic [7:0]  CNT_ADDR,
    input  logic        CNT_WE,
    input  logic [15:0] CNT_DIN,
    output logic [15:0] CNT_DOUT,
    input  logic [14:0] MOD_IDX,
    output logic [7:0]  MOD_VALUE,
    input  logic [12:0] STM_IDX,
    output logic [63:0] STM_VALUE,
    input  logic [15:0] DT_IDX,
    output logic [7:0]  DT_VALUE
);

    // Smallest intensity whose rounded pulse width reaches k.
    function automatic logic [16:0] dt_thr(input int k);
        return 17'(int'($ceil(65025.0 * $sin((real'(k) - 0.5) * 3.141592653589793 / 512.0))));
    endfunction

    logic [15:0]       ctl_mem [256];
    logic [15:0]       mod_mem [16384];
    logic [15:0]       dt_mem  [32768];
    logic              dt_wr   [32768];
    logic [3:0][15:0]  stm_mem [8192];

    logic        host_wr;
    logic        h_rd_d, h_rd_q, h_ctl_d, h_ctl_q;
    logic [15:0] h_word_d, h_word_q, c_word_d, c_word_q;
    logic [15:0] m_word_d, m_word_q, d_word_d, d_word_q;
    logic        m_hi_d, m_hi_q, d_wr_d, d_wr_q;
    logic [63:0] s_entry_d, s_entry_q;
    logic [15:0] d_idx_d, d_idx_q;
    logic [15:0] mem_dout_d, mem_dout_q, cnt_dout_d, cnt_dout_q;
    logic [7:0]  mod_value_d, mod_value_q, dt_value_d, dt_value_q;
    logic [63:0] stm_value_d, stm_value_q;
    logic [254:0] dt_ge;
    logic [7:0]  dt_rom;

    assign host_wr = RST_N & MEM_EN & MEM_WE;

    // Internal write is applied last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (host_wr && MEM_SEL == 2'd0) ctl_mem[MEM_ADDR[7:0]] <= MEM_DIN;
        if (RST_N && CNT_WE) ctl_mem[CNT_ADDR] <= CNT_DIN;
    end

    always_ff @(posedge CLK)
        if (host_wr && MEM_SEL == 2'd1) mod_mem[MEM_ADDR[13:0]] <= MEM_DIN;

    always_ff @(posedge CLK)
        if (host_wr && MEM_SEL == 2'd2) begin
            dt_mem[MEM_ADDR] <= MEM_DIN;
            dt_wr[MEM_ADDR]  <= 1'b1;
        end

    always_ff @(posedge CLK)
        if (host_wr && MEM_SEL == 2'd3) stm_mem[MEM_ADDR[14:2]][MEM_ADDR[1:0]] <= MEM_DIN;

    for (genvar k = 1; k < 256; k++) begin : g_thr
        localparam logic [16:0] THR = dt_thr(k);
        assign dt_ge[k-1] = {1'b0, d_idx_q} >= THR;
    end

    always_comb begin
        dt_rom = '0;
        for (int i = 0; i < 255; i++) dt_rom = dt_rom + 8'(dt_ge[i]);
    end

    always_comb begin
        h_rd_d      = MEM_EN & ~MEM_WE;
        h_ctl_d     = MEM_SEL == 2'd0;
        h_word_d    = ctl_mem[MEM_ADDR[7:0]];
        c_word_d    = ctl_mem[CNT_ADDR];
        m_word_d    = mod_mem[MOD_IDX[14:1]];
        m_hi_d      = MOD_IDX[0];
        s_entry_d   = stm_mem[STM_IDX];
        d_word_d    = dt_mem[DT_IDX[15:1]];
        d_wr_d      = dt_wr[DT_IDX[15:1]];
        d_idx_d     = DT_IDX;
        mem_dout_d  = h_rd_q ? (h_ctl_q ? h_word_q : 16'h0000) : mem_dout_q;
        cnt_dout_d  = c_word_q;
        mod_value_d = m_hi_q ? m_word_q[15:8] : m_word_q[7:0];
        stm_value_d = s_entry_q;
        dt_value_d  = d_wr_q ? (d_idx_q[0] ? d_word_q[15:8] : d_word_q[7:0]) : dt_rom;
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            h_rd_q      <= 1'b0;
            h_ctl_q     <= 1'b0;
            h_word_q    <= '0;
            c_word_q    <= '0;
            m_word_q    <= '0;
            m_hi_q      <= 1'b0;
            s_entry_q   <= '0;
            d_word_q    <= '0;
            d_wr_q      <= 1'b0;
            d_idx_q     <= '0;
            mem_dout_q  <= '0;
            cnt_dout_q  <= '0;
            mod_value_q <= '0;
            stm_value_q <= '0;
            dt_value_q  <= '0;
        end else begin
            h_rd_q      <= h_rd_d;
            h_ctl_q     <= h_ctl_d;
            h_word_q    <= h_word_d;
            c_word_q    <= c_word_d;
            m_word_q    <= m_word_d;
            m_hi_q      <= m_hi_d;
            s_entry_q   <= s_entry_d;
            d_word_q    <= d_word_d;
            d_wr_q      <= d_wr_d;
            d_idx_q     <= d_idx_d;
            mem_dout_q  <= mem_dout_d;
            cnt_dout_q  <= cnt_dout_d;
            mod_value_q <= mod_value_d;
            stm_value_q <= stm_value_d;
            dt_value_q  <= dt_value_d;
        end

    assign MEM_DOUT  = mem_dout_q;
    assign CNT_DOUT  = cnt_dout_q;
    assign MOD_VALUE = mod_value_q;
    assign STM_VALUE = stm_value_q;
    assign DT_VALUE  = dt_value_q;

endmodule

// File: tb/tb_memory_hub.sv
// tb_memory_hub: directed and randomized checks of memory_hub against a byte-level reference model.
module tb_memory_hub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en, mem_we;
    logic [1:0]  mem_sel;
    logic [14:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic [7:0]  cnt_addr;
    logic        cnt_we;
    logic [15:0] cnt_din, cnt_dout;
    logic [14:0] mod_idx;
    logic [7:0]  mod_value;
    logic [12:0] stm_idx;
    logic [63:0] stm_value;
    logic [15:0] dt_idx;
    logic [7:0]  dt_value;

    int errors = 0;
    int checks = 0;

    logic [15:0] ctlm [256];
    logic [7:0]  modm [32768];
    logic [7:0]  dtm  [65536];
    logic [15:0] stmw [32768];
    logic [15:0] dout_m;

    typedef struct {
        logic [15:0] md;
        logic [15:0] cd;
        logic [7:0]  mv;
        logic [63:0] sv;
        logic [7:0]  dv;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    memory_hub dut (
        .CLK(clk), .RST_N(rst_n),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_SEL(mem_sel), .MEM_ADDR(mem_addr),
        .MEM_DIN(mem_din), .MEM_DOUT(mem_dout),
        .CNT_ADDR(cnt_addr), .CNT_WE(cnt_we), .CNT_DIN(cnt_din), .CNT_DOUT(cnt_dout),
        .MOD_IDX(mod_idx), .MOD_VALUE(mod_value),
        .STM_IDX(stm_idx), .STM_VALUE(stm_value),
        .DT_IDX(dt_idx), .DT_VALUE(dt_value)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [1:0] sel, input logic [14:0] addr, input logic [15:0] din);
        case (sel)
            2'd0: ctlm[addr[7:0]] = din;
            2'd1: begin modm[{addr[13:0], 1'b0}] = din[7:0]; modm[{addr[13:0], 1'b1}] = din[15:8]; end
            2'd2: begin dtm[{addr, 1'b0}] = din[7:0]; dtm[{addr, 1'b1}] = din[15:8]; end
            default: stmw[addr] = din;
        endcase
    endfunction

    function automatic logic [63:0] stm_entry(input int n);
        return {stmw[4*n+3], stmw[4*n+2], stmw[4*n+1], stmw[4*n]};
    endfunction

    task automatic host_write(input logic [1:0] sel, input logic [14:0] addr, input logic [15:0] din);
        mem_en = 1'b1; mem_we = 1'b1; mem_sel = sel; mem_addr = addr; mem_din = din;
        model_write(sel, addr, din);
        tick();
        mem_en = 1'b0; mem_we = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [1:0] sel, input logic [14:0] addr);
        mem_en = 1'b1; mem_we = 1'b0; mem_sel = sel; mem_addr = addr;
        tick();
        mem_en = 1'b0;
        tick();
        dout_m = (sel == 2'd0) ? ctlm[addr[7:0]] : 16'h0000;
        chk(tag, mem_dout, dout_m);
    endtask

    task automatic dt_read(input string tag, input logic [15:0] idx, input logic [7:0] exp);
        dt_idx = idx;
        tick();
        tick();
        chk(tag, dt_value, exp);
    endtask

    task automatic cnt_read(input string tag, input logic [7:0] addr, input logic [15:0] exp);
        cnt_addr = addr;
        tick();
        tick();
        chk(tag, cnt_dout, exp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ctlm[i] = '0;
        for (int i = 0; i < 32768; i++) begin modm[i] = '0; stmw[i] = '0; end
        for (int i = 0; i < 65536; i++)
            dtm[i] = (i < 65025) ? 8'($rtoi($floor($asin(real'(i) / 65025.0) * 2.0 / 3.141592653589793 * 256.0 + 0.5))) : 8'd255;
        dout_m = '0;
        mem_en = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_din = 0;
        cnt_addr = 0; cnt_we = 0; cnt_din = 0; mod_idx = 0; stm_idx = 0; dt_idx = 0;

        repeat (3) tick();
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_cnt_dout", cnt_dout, 0);
        chk("rst_mod", mod_value, 0);
        chk("rst_stm", stm_value, 0);
        chk("rst_dt", dt_value, 0);
        rst_n = 1'b1;
        tick();

        dt_read("dt_def_0", 16'd0, 8'd0);
        dt_idx = 16'd16256;
        tick();
        chk("dt_latency_1cyc", dt_value, 8'd0);
        tick();
        chk("dt_def_16256", dt_value, 8'd41);
        dt_read("dt_def_32512", 16'd32512, 8'd85);
        dt_read("dt_def_65024", 16'd65024, 8'd255);

        host_write(2'd2, 15'h10, 16'hABCD);
        dt_read("dt_wr_lo", 16'h20, 8'hCD);
        dt_read("dt_wr_hi", 16'h21, 8'hAB);

        for (int i = 0; i < 65538; i++) begin
            if (i >= 2) chk("dt_sweep", dt_value, dtm[i-2]);
            if (i < 65536) dt_idx = 16'(i);
            tick();
        end

        host_write(2'd0, 15'd5, 16'h1234);
        cnt_read("cnt_after_host", 8'd5, 16'h1234);
        cnt_we = 1'b1; cnt_addr = 8'd5; cnt_din = 16'h5678; ctlm[5] = 16'h5678;
        tick();
        cnt_we = 1'b0;
        host_read("host_rd_after_cnt", 2'd0, 15'd5);
        repeat (3) tick();
        chk("host_rd_hold", mem_dout, 16'h5678);
        host_read("host_rd_hi_ignored", 2'd0, 15'h7F05);

        mem_en = 1; mem_we = 1; mem_sel = 2'd0; mem_addr = 15'd9; mem_din = 16'h1111;
        cnt_we = 1; cnt_addr = 8'd9; cnt_din = 16'h2222;
        ctlm[9] = 16'h1111; ctlm[9] = 16'h2222;
        tick();
        mem_en = 0; mem_we = 0; cnt_we = 0;
        cnt_read("collision_cnt", 8'd9, 16'h2222);
        host_read("collision_host", 2'd0, 15'd9);
        host_read("host_rd_duty_zero", 2'd2, 15'h10);

        for (int w = 0; w < 4; w++) host_write(2'd3, 15'(w), 16'(w + 1));
        stm_idx = 13'd0;
        tick(); tick();
        chk("stm_entry0", stm_value, 64'h0004_0003_0002_0001);
        host_write(2'd1, 15'd0, 16'h00FF);
        mod_idx = 15'd0;
        tick(); tick();
        chk("mod_byte0", mod_value, 8'hFF);
        mod_idx = 15'd1;
        tick(); tick();
        chk("mod_byte1", mod_value, 8'h00);

        for (int i = 0; i < 600; i++) begin
            exp_t e;
            if (q.size() == 2) begin
                e = q.pop_front();
                chk("rnd_mem_dout", mem_dout, e.md);
                chk("rnd_cnt_dout", cnt_dout, e.cd);
                chk("rnd_mod", mod_value, e.mv);
                chk("rnd_stm", stm_value, e.sv);
                chk("rnd_dt", dt_value, e.dv);
            end
            mem_en  = 1'($urandom_range(0, 1));
            mem_we  = 1'($urandom_range(0, 1));
            mem_sel = 2'($urandom_range(0, 3));
            mem_din = 16'($urandom);
            case (mem_sel)
                2'd0: mem_addr = {7'($urandom), 8'($urandom_range(0, 15))};
                2'd1: mem_addr = {1'($urandom), 14'($urandom_range(0, 15))};
                default: mem_addr = 15'($urandom_range(0, 15));
            endcase
            cnt_we   = ($urandom_range(0, 3) == 0);
            cnt_addr = 8'($urandom_range(0, 15));
            cnt_din  = 16'($urandom);
            mod_idx  = 15'($urandom_range(0, 31));
            stm_idx  = 13'($urandom_range(0, 3));
            dt_idx   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            e.md = (mem_en && !mem_we) ? ((mem_sel == 2'd0) ? ctlm[mem_addr[7:0]] : 16'h0000) : dout_m;
            dout_m = e.md;
            e.cd = ctlm[cnt_addr];
            e.mv = modm[mod_idx];
            e.sv = stm_entry(int'(stm_idx));
            e.dv = dtm[dt_idx];
            q.push_back(e);
            if (mem_en && mem_we) model_write(mem_sel, mem_addr, mem_din);
            if (cnt_we) ctlm[cnt_addr] = cnt_din;
            tick();
        end
        mem_en = 0; mem_we = 0; cnt_we = 0;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("drain_mem_dout", mem_dout, e.md);
            chk("drain_cnt_dout", cnt_dout, e.cd);
            chk("drain_mod", mod_value, e.mv);
            chk("drain_stm", stm_value, e.sv);
            chk("drain_dt", dt_value, e.dv);
            tick();
        end

        host_write(2'd0, 15'd9, 16'hC0DE);
        host_read("pre_rst_host", 2'd0, 15'd9);
        dt_read("pre_rst_dt", 16'd65024, 8'd255);
        for (int i = 0; i < 3; i++) begin
            dt_idx = 16'(32000 + i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_dout", mem_dout, 0);
        chk("midrst_cnt_dout", cnt_dout, 0);
        chk("midrst_mod", mod_value, 0);
        chk("midrst_stm", stm_value, 0);
        chk("midrst_dt", dt_value, 0);
        mem_en = 1; mem_we = 1; mem_sel = 2'd0; mem_addr = 15'd9; mem_din = 16'hDEAD;
        cnt_we = 1; cnt_addr = 8'd7; cnt_din = 16'hBEEF;
        tick(); tick();
        mem_en = 0; mem_we = 0; cnt_we = 0;
        rst_n = 1'b1;
        dt_read("post_rst_dt", 16'd32512, 8'd85);
        chk("post_rst_dout_zero", mem_dout, 0);
        cnt_read("post_rst_ign_host", 8'd9, ctlm[9]);
        cnt_read("post_rst_ign_cnt", 8'd7, ctlm[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
